// File: rtl/pkt_sink.sv
// pkt_sink: credit-controlled bus sink with a registered FIFO, per-word parity
// checking and packet framing, presented on a valid/ready stream.
//
// state  | meaning
// IDLE   | next popped word starts a packet (out_sop=1)
// IN_PKT | inside a packet; id latched, word_cnt counts words popped so far
module pkt_sink #(
  parameter int DATA_SIZE     = 64,
  parameter int CTL_SIZE      = 3,
  parameter int PAYLOAD       = 32,
  parameter int FLAGS         = 11,
  parameter int ADDR          = 20,
  parameter int ID            = 2,
  parameter int CREDITS       = 16,
  parameter int MAX_PKT_WORDS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bus_valid,
  input  logic [DATA_SIZE+CTL_SIZE-1:0] sub_sys_bus,
  output logic                          credit_ret,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PAYLOAD-1:0]            out_payload,
  output logic [FLAGS-1:0]              out_flags,
  output logic [ADDR-1:0]               out_addr,
  output logic [ID-1:0]                 out_id,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic                          out_ecc_err,
  output logic [15:0]                   ecc_err_cnt,
  output logic                          ovf_err,
  output logic                          proto_err
);

  localparam int W        = DATA_SIZE + CTL_SIZE;
  localparam int PW       = (CREDITS > 1) ? $clog2(CREDITS) : 1;
  localparam int CW       = $clog2(CREDITS + 1);
  localparam int WCW      = $clog2(MAX_PKT_WORDS + 1);
  localparam int ID_LO    = 1;
  localparam int ADDR_LO  = ID_LO + ID;
  localparam int ECC_B    = ADDR_LO + ADDR;
  localparam int FLAGS_LO = ECC_B + 1;
  localparam int PAY_LO   = FLAGS_LO + FLAGS;

  localparam logic [CW-1:0]  FULL     = CW'(CREDITS);
  localparam logic [PW-1:0]  PTR_LAST = PW'(CREDITS - 1);
  localparam logic [WCW-1:0] WC_LAST  = WCW'(MAX_PKT_WORDS - 1);

  typedef enum logic {IDLE, IN_PKT} state_t;

  logic [W-1:0]   mem [CREDITS];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           push, pop, ovf_set, proto_set;

  logic [W-1:0]       head;
  logic [PAYLOAD-1:0] head_payload;
  logic [FLAGS-1:0]   head_flags;
  logic [ADDR-1:0]    head_addr;
  logic [ID-1:0]      head_id;
  logic               head_eop, head_ecc, head_parity_bad;

  state_t         state, state_nx;
  logic [WCW-1:0] word_cnt, word_cnt_nx;
  logic [ID-1:0]  id_q, id_nx;
  logic           force_term, id_bad;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // At full, a same-cycle pop frees the slot being written, so the push is taken.
  assign push      = bus_valid && ((count != FULL) || pop);
  assign ovf_set   = bus_valid && (count == FULL) && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sub_sys_bus;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head            = mem[rd_ptr];
  assign head_payload    = head[PAY_LO +: PAYLOAD];
  assign head_flags      = head[FLAGS_LO +: FLAGS];
  assign head_ecc        = head[ECC_B];
  assign head_addr       = head[ADDR_LO +: ADDR];
  assign head_id         = head[ID_LO +: ID];
  assign head_eop        = head[0];
  assign head_parity_bad = head_ecc ^ (^{head_payload, head_flags, head_addr});

  assign out_payload = out_valid ? head_payload : '0;
  assign out_flags   = out_valid ? head_flags   : '0;
  assign out_addr    = out_valid ? head_addr    : '0;
  assign out_id      = out_valid ? head_id      : '0;
  assign out_ecc_err = out_valid && head_parity_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      id_q     <= '0;
    end else begin
      state    <= state_nx;
      word_cnt <= word_cnt_nx;
      id_q     <= id_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    word_cnt_nx = word_cnt;
    id_nx       = id_q;
    if (pop) begin
      case (state)
        IDLE: begin
          id_nx       = head_id;
          word_cnt_nx = WCW'(1);
          state_nx    = head_eop ? IDLE : IN_PKT;
        end
        IN_PKT: begin
          if (head_eop || force_term) begin
            state_nx    = IDLE;
            word_cnt_nx = '0;
          end else begin
            word_cnt_nx = word_cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    force_term = (state == IN_PKT) && (word_cnt == WC_LAST) && !head_eop;
    id_bad     = (state == IN_PKT) && (head_id != id_q);
    out_sop    = out_valid && (state == IDLE);
    out_eop    = out_valid && (head_eop || force_term);
    proto_set  = pop && (id_bad || force_term);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_ret  <= 1'b0;
      ovf_err     <= 1'b0;
      proto_err   <= 1'b0;
      ecc_err_cnt <= '0;
    end else begin
      credit_ret <= pop;
      if (ovf_set)   ovf_err   <= 1'b1;
      if (proto_set) proto_err <= 1'b1;
      if (pop && head_parity_bad && (ecc_err_cnt != 16'hFFFF))
        ecc_err_cnt <= ecc_err_cnt + 1'b1;
    end
  end

endmodule
